bytes_to_bits_seq: RTL
======================

# bytes_to_bits_seq

Sequential controller for the Kyber byte-to-bit conversion step. It accepts a job of `len` bytes and pulls bytes one at a time over a valid/ready byte stream. It emits the equivalent bit string serially, LSB-first, over a valid/ready bit stream. Global bit index `8*i+j` carries bit `j` of byte `i`, the same ordering as the combinational converter's `b[i*8 +: 8] = B[i]`. It sits between the byte-oriented hash/PRF output and bit-serial consumers (CBD sampling, decode).

## Interface
Parameters:
- `MAX_BYTES`, 256, largest job length in bytes.
- `LEN_W`, `$clog2(MAX_BYTES)+1`, width of the length field (9 at default).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_W  job length in bytes; captured with `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `byte_valid`  in  1  upstream byte present.
- `byte_data`  in  8  upstream byte.
- `byte_ready`  out  1  controller will take a byte this cycle.
- `bit_valid`  out  1  `bit_data` is valid.
- `bit_data`  out  1  current output bit.
- `bit_ready`  in  1  downstream accepts the bit.
- `bit_last`  out  1  qualifies the final bit of the job; only meaningful with `bit_valid`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- The FSM has four states: IDLE, FETCH, SHIFT and DONE.
- IDLE:
  - `start`=1 captures `len` into `bytes_left`.
  - A captured `len` greater than MAX_BYTES is clamped to MAX_BYTES.
  - If the captured length is 0, go to DONE; otherwise go to FETCH.
- FETCH:
  - `byte_ready`=1.
  - On `byte_valid && byte_ready`: load `byte_data` into an 8-bit shift register, clear the 3-bit `bit_cnt`, decrement `bytes_left`, and go to SHIFT.
- SHIFT:
  - `bit_valid`=1 and `bit_data`=`sreg[0]`.
  - On `bit_valid && bit_ready`: shift `sreg` right and increment `bit_cnt`.
  - When `bit_cnt`==7 is handshaken, go to FETCH if `bytes_left`≠0, else go to DONE.
- `bit_last` = SHIFT && `bit_cnt`==7 && `bytes_left`==0.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored in every state other than IDLE; no queuing.
- With `bit_valid`=1 and `bit_ready`=0, `bit_data` and `bit_last` are held stable.
- `byte_ready` is never asserted outside FETCH.
- Counters never wrap:
  - `bytes_left` only decrements from a nonzero value.
  - `bit_cnt` 7→0 happens only on exit from SHIFT.

## Timing
- Reset values: state IDLE, `busy`=0, `byte_ready`=0, `bit_valid`=0, `bit_data`=0, `bit_last`=0, `done`=0, all counters 0, `sreg`=0.
- Reset asserted mid-job aborts immediately and asynchronously. No `done` pulse is produced and no partial state survives.
- `start` at cycle t produces `busy`=1 at t+1 and `byte_ready`=1 at t+1 (FETCH).
- A byte handshake at cycle t produces `bit_valid`=1 at t+1.
- Each byte costs 8 bit-handshake cycles plus at least one FETCH cycle. Minimum job latency with no stalls is 1 + 9·len cycles from `start` to the last bit, with `done` on the following cycle.
- `len`=0: `done` asserts at t+1 after `start`, with no byte or bit traffic.
- The final bit handshake at cycle t produces `done`=1 at t+1 and `busy`=0 at t+2.
- Simultaneous `start` and DONE: `start` is ignored, since it is only sampled in IDLE.

## Configuration
- Macro `BYTES_TO_BITS_SEQ_BITIDX_EN`.
- Defined: adds output port `bit_idx` [LEN_W+2:0], equal to the global index `8*(len_cap-bytes_left-1)+bit_cnt` of the current bit. `len_cap` is the captured, clamped length. `bit_idx` is valid with `bit_valid` and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- **Two-byte job:** `len`=2, bytes 0x01 then 0x80, `bit_ready`=1 → bit stream 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1. `bit_last` is high only on bit 16. `done` is one cycle after that bit.
- **Full-length job:** `len`=256, byte i = i → 2048 bits. Regrouping every 8 bits LSB-first reproduces bytes 0..255. Total 2305 cycles from `start` to the last bit with no stalls.
- **Zero length:** `len`=0 → `done` at t+1, `byte_ready` and `bit_valid` never asserted, `busy` high for exactly 1 cycle.
- **Backpressure and clamp:**
  - Random `bit_ready`/`byte_valid` on `len`=5 → `bit_data` is stable while stalled and the stream equals the unstalled reference.
  - `len`=300 → exactly 256 bytes are consumed.
- **Reset mid-job:** `rst_n` low during SHIFT of byte 3 → all outputs 0 at once. A new `start` after release with `len`=1 (0xA5) yields 1,0,1,0,0,1,0,1.
- **Start while busy:** `start` pulsed during SHIFT and during DONE → ignored, and the job length is unchanged.

Source files
------------

// File: rtl/bytes_to_bits_seq.sv
// Byte-stream to LSB-first bit-stream controller for Kyber byte-to-bit conversion.
// Optional bit_idx output is enabled by defining BYTES_TO_BITS_SEQ_BITIDX_EN.
module bytes_to_bits_seq #(
    parameter int MAX_BYTES = 256,
    parameter int LEN_W     = $clog2(MAX_BYTES) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             bit_valid,
    output logic             bit_data,
    input  logic             bit_ready,
    output logic             bit_last,
    output logic             done
`ifdef BYTES_TO_BITS_SEQ_BITIDX_EN
    ,
    output logic [LEN_W+2:0] bit_idx
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_bytes_left;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_sreg;
    logic [LEN_W-1:0] w_len_cap;
    logic             w_byte_hs;
    logic             w_bit_hs;
    logic             w_cnt_end;

    assign w_len_cap = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
    assign w_byte_hs = (r_state == S_FETCH) && byte_valid;
    assign w_bit_hs  = (r_state == S_SHIFT) && bit_ready;
    assign w_cnt_end = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_len_cap == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_byte_hs) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_bit_hs && w_cnt_end) begin
                    w_next = (r_bytes_left != '0) ? S_FETCH : S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FETCH is only entered with bytes_left nonzero, so the decrement never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bytes_left <= '0;
            r_bit_cnt    <= '0;
            r_sreg       <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_bytes_left <= w_len_cap;
            end
            if (w_byte_hs) begin
                r_sreg       <= byte_data;
                r_bit_cnt    <= '0;
                r_bytes_left <= r_bytes_left - LEN_W'(1);
            end
            if (w_bit_hs) begin
                r_sreg    <= {1'b0, r_sreg[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        busy       = 1'b0;
        byte_ready = 1'b0;
        bit_valid  = 1'b0;
        bit_data   = 1'b0;
        bit_last   = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
            end
            S_FETCH: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
            end
            S_SHIFT: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                bit_data  = r_sreg[0];
                bit_last  = w_cnt_end && (r_bytes_left == '0);
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef BYTES_TO_BITS_SEQ_BITIDX_EN
    logic [LEN_W-1:0] r_len_cap;
    logic [LEN_W-1:0] w_byte_no;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_cap <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_len_cap <= w_len_cap;
        end
    end

    // bytes_left has already been decremented for the byte being shifted.
    assign w_byte_no = r_len_cap - r_bytes_left - LEN_W'(1);
    assign bit_idx   = (r_state == S_SHIFT) ? {w_byte_no, r_bit_cnt} : '0;
`endif

endmodule
